sig_cluster_reader: RTL and testbench
=====================================

Name: sig_cluster_reader

Overview:
- Read side of the background-subtracted signal RAM (ram4sig) and consumer of the cluster-locate results.
- On each end-of-frame pulse, reads the located cluster channels [left..right] from the RAM through its read port.
- Accumulates the charge sum and the channel-weighted sum for downstream centroid calculation.
- Emits one Avalon-ST packet per frame toward the UDP path.

Parameters:
- RD_LATENCY, 2, RAM read latency in clocks, from rdaddress valid to sig_out valid; legal range 1..3.
- MAX_WIDTH, 64, maximum number of channels read per cluster; legal range 1..320.
- NUM_CH, 320, channel count; the highest legal address is NUM_CH-1.
- MAGIC, 5'h15, tag placed in header word 0 bits [31:27].

Ports:
- clk_clk  in  1  system clock; this block uses a single clock.
- rst_reset_n  in  1  reset, asynchronous and active-low.
- frameID  in  27  current frame number.
- sig_ram_last  in  1  one-cycle pulse; the frame's signal RAM content is complete.
- has_cluster  in  1  cluster found, from cluster_locate.
- no_cluster  in  1  no cluster found, from cluster_locate.
- sig_ch_left  in  9  first cluster channel.
- sig_ch_right  in  9  last cluster channel.
- sig_rdaddress  out  9  RAM read address.
- sig_out  in  32  RAM read data; bits [15:0] carry the signed sample.
- data_out_data  out  32  Avalon-ST source data.
- data_out_valid  out  1  Avalon-ST source valid.
- data_out_ready  in  1  Avalon-ST source ready.
- data_out_startofpacket  out  1  Avalon-ST source start of packet.
- data_out_endofpacket  out  1  Avalon-ST source end of packet.
- data_out_empty  out  2  constant 0.
- busy  out  1  high whenever the state is not IDLE.
- drop_count  out  8  saturating count of sig_ram_last pulses ignored while busy.

Behaviour:
- Reset values: all outputs 0, state IDLE. An asynchronous reset mid-packet aborts the packet immediately; no eop is emitted.
- Capture: in IDLE, a cycle with sig_ram_last=1 latches frameID, has_cluster, left and right, and the block moves to HDR0.
- Cluster validity: the cluster is valid when has_cluster=1, left<=right and left<NUM_CH.
- Channel clamping: right is clamped to NUM_CH-1.
- Truncation: if right-left+1 > MAX_WIDTH, then right = left+MAX_WIDTH-1 and trunc=1.
- Invalid cluster: count=0 and the sample phase is skipped.
- Packet format, in order:
  - HDR0 = {MAGIC, frameID}, with sop=1.
  - HDR1 = {has, trunc, 3'b0, left, right, count}.
  - count sample words, each {7'b0, ch[8:0], sample[15:0]}.
  - SUM, a 32-bit signed word.
  - WSUM, a 32-bit signed word, with eop=1.
- Handshake: a word transfers on valid&&ready. valid, once asserted, holds with stable data until ready. sop and eop are valid only with valid.
- State transitions:
  - IDLE -> HDR0 -> HDR1 -> (count>0 ? RD_ISSUE : SUM).
  - RD_ISSUE drives sig_rdaddress=ch, then goes to RD_WAIT for RD_LATENCY cycles.
  - After RD_WAIT, sig_out[15:0] is latched into a holding register and the block enters SAMPLE (valid=1).
  - On SAMPLE accept: accumulate, ch+1; if ch==right go to SUM, else go to RD_ISSUE.
  - SUM -> WSUM -> IDLE, each transition on accept.
- Throughput: one sample per RD_LATENCY+2 clocks minimum. Backpressure holds the holding register; the RAM is not re-read.
- Arithmetic:
  - sum += sign-extended sample.
  - wsum += $signed({1'b0,ch}) * sample, a 25-bit product sign-extended to 32 bits.
  - Accumulators clear on capture.
  - At MAX_WIDTH ≤ 64 no overflow occurs. Above 64 the 32-bit result wraps mod 2^32, which is documented behaviour.
- Busy handling: a sig_ram_last pulse while busy is ignored and drop_count increments, saturating at 255.
- sig_rdaddress holds its last value outside RD_ISSUE/RD_WAIT.

Optional Feature:
- Macro: SIG_READER_NEG_CLIP_EN.
- When defined: negative samples are treated as 0 in both accumulators; the sample words still carry the raw value.
- When undefined: signed accumulation of raw samples.

Decomposition:
- Shared package sig_reader_pkg holds:
  - the state enum;
  - MAGIC;
  - the header field position constants;
  - the sample word layout;
  - NUM_CH.
- Sub-module cluster_accumulator:
  - inputs: clear, enable, ch, sample;
  - outputs: sum and wsum;
  - contains the NEG_CLIP logic.

Test Plan:
- Nominal cluster: RAM ch10..13 = 100,200,300,100; left=10, right=13, has=1, frameID=5.
  - Expect packet HDR0=0xA8000005 and HDR1 count=4.
  - Expect 4 samples, SUM=700, WSUM=8100; sop on word 0 and eop on word 7 only.
- Backpressure: same stimulus with data_out_ready toggling 1-0-0-1 repeatedly.
  - Expect identical words, data stable while stalled, and no duplicates or skips.
- No cluster: no_cluster=1, has=0.
  - Expect a 4-word packet with HDR1 has=0 and count=0, SUM=0, WSUM=0, eop on WSUM.
- Truncation: left=0, right=100, MAX_WIDTH=64.
  - Expect HDR1 right=63, trunc=1, count=64, and 64 sample words.
- Signed data and drop: ch5=-50, ch6=80.
  - Without the macro: SUM=30, WSUM=230. With SIG_READER_NEG_CLIP_EN: SUM=80, WSUM=480.
  - A second sig_ram_last mid-packet gives drop_count=1 and the current packet is unaffected.
- Reset mid-packet: assert rst_reset_n low during the sample phase.
  - Expect valid=0 immediately and state IDLE.
  - Expect the next sig_ram_last to produce a complete, correct packet.

Source files
------------

// File: rtl/sig_reader_pkg.sv
// Shared definitions for the cluster signal reader.
//
// Holds the reader state encoding, the header tag, the default channel
// count and the bit positions of every field in the outgoing words,
// together with small packing helpers so the top never hand-assembles a
// word layout.
//
// Word layouts:
//   HDR0   : [31:27] magic, [26:0] frame number
//   HDR1   : [31] has, [30] trunc, [29:27] 0, [26:18] left,
//            [17:9] right, [8:0] count
//   SAMPLE : [31:25] 0, [24:16] channel, [15:0] raw sample
package sig_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HDR0     = 3'd1,
    S_HDR1     = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_SAMPLE   = 3'd5,
    S_SUM      = 3'd6,
    S_WSUM     = 3'd7
  } sig_state_e;

  localparam logic [4:0] MAGIC_DEFAULT  = 5'h15;
  localparam int         NUM_CH_DEFAULT = 320;

  localparam int HDR0_MAGIC_LSB = 27;
  localparam int HDR0_FRAME_LSB = 0;

  localparam int HDR1_HAS_BIT   = 31;
  localparam int HDR1_TRUNC_BIT = 30;
  localparam int HDR1_LEFT_LSB  = 18;
  localparam int HDR1_RIGHT_LSB = 9;
  localparam int HDR1_COUNT_LSB = 0;

  localparam int SMP_CH_LSB   = 16;
  localparam int SMP_DATA_LSB = 0;

  function automatic logic [31:0] pack_hdr0(input logic [4:0]  magic,
                                            input logic [26:0] frame);
    logic [31:0] w;
    w = '0;
    w[HDR0_MAGIC_LSB +: 5]  = magic;
    w[HDR0_FRAME_LSB +: 27] = frame;
    return w;
  endfunction

  function automatic logic [31:0] pack_hdr1(input logic       has,
                                            input logic       trunc,
                                            input logic [8:0] left,
                                            input logic [8:0] right,
                                            input logic [8:0] count);
    logic [31:0] w;
    w = '0;
    w[HDR1_HAS_BIT]          = has;
    w[HDR1_TRUNC_BIT]        = trunc;
    w[HDR1_LEFT_LSB  +: 9]   = left;
    w[HDR1_RIGHT_LSB +: 9]   = right;
    w[HDR1_COUNT_LSB +: 9]   = count;
    return w;
  endfunction

  function automatic logic [31:0] pack_sample(input logic [8:0]  ch,
                                              input logic [15:0] sample);
    logic [31:0] w;
    w = '0;
    w[SMP_CH_LSB   +: 9]  = ch;
    w[SMP_DATA_LSB +: 16] = sample;
    return w;
  endfunction

endpackage

// File: rtl/sig_cluster_reader_accum.sv
// Charge and channel-weighted charge accumulators for one cluster.
//
// Ports:
//   clk_clk, rst_reset_n : clock, asynchronous active-low reset
//   clear                : zero both accumulators (wins over enable)
//   enable               : add the current channel/sample pair
//   ch                   : channel number of the sample (unsigned)
//   sample               : signed 16-bit background-subtracted sample
//   sum                  : running sum of samples (32-bit signed)
//   wsum                 : running sum of ch*sample (32-bit signed)
//
// Build option SIG_READER_NEG_CLIP_EN: negative samples contribute 0 to
// both accumulators. Otherwise raw signed samples are accumulated.
// The 32-bit totals wrap modulo 2^32 for very wide clusters.
module cluster_accumulator
  import sig_reader_pkg::*;
(
  input  logic        clk_clk,
  input  logic        rst_reset_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [8:0]  ch,
  input  logic [15:0] sample,
  output logic [31:0] sum,
  output logic [31:0] wsum
);

  logic signed [15:0] smp_eff;
  logic signed [25:0] prod;
  logic signed [31:0] sum_q;
  logic signed [31:0] wsum_q;

  always_comb begin
`ifdef SIG_READER_NEG_CLIP_EN
    smp_eff = sample[15] ? 16'sd0 : $signed(sample);
`else
    smp_eff = $signed(sample);
`endif
    // Channel is unsigned, so a zero bit is prepended before the signed
    // multiply; |ch*sample| < 2^24, so the product never overflows.
    prod = $signed({1'b0, ch}) * smp_eff;
  end

  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      sum_q  <= '0;
      wsum_q <= '0;
    end else if (clear) begin
      sum_q  <= '0;
      wsum_q <= '0;
    end else if (enable) begin
      sum_q  <= sum_q + {{16{smp_eff[15]}}, smp_eff};
      wsum_q <= wsum_q + {{6{prod[25]}}, prod};
    end
  end

  assign sum  = sum_q;
  assign wsum = wsum_q;

endmodule

// File: rtl/sig_cluster_reader.sv
// Cluster signal reader: on each end-of-frame pulse, reads the located
// cluster channels from the signal RAM, accumulates charge and
// channel-weighted charge, and emits one Avalon-ST packet per frame.
//
// Packet: HDR0 (sop), HDR1, <count> sample words, SUM, WSUM (eop).
//
// Ports:
//   clk_clk, rst_reset_n       : clock, asynchronous active-low reset
//   frameID                    : frame number, captured at sig_ram_last
//   sig_ram_last               : one-cycle pulse, RAM content complete
//   has_cluster, no_cluster    : cluster_locate result flags
//   sig_ch_left, sig_ch_right  : cluster channel range
//   sig_rdaddress, sig_out     : RAM read port (RD_LATENCY clocks)
//   data_out_*                 : Avalon-ST source (empty tied to 0)
//   busy                       : state is not IDLE
//   drop_count                 : saturating count of pulses seen while busy
//   dbg_state                  : current FSM state encoding
//
// Handshake: a word moves when valid && ready. Once valid rises it stays
// high with unchanged data/sop/eop until ready; sop/eop are only ever
// high together with valid.
//
// Build option SIG_READER_NEG_CLIP_EN (see cluster_accumulator).
module sig_cluster_reader
  import sig_reader_pkg::*;
#(
  parameter int         RD_LATENCY = 2,
  parameter int         MAX_WIDTH  = 64,
  parameter int         NUM_CH     = NUM_CH_DEFAULT,
  parameter logic [4:0] MAGIC      = MAGIC_DEFAULT
) (
  input  logic        clk_clk,
  input  logic        rst_reset_n,
  input  logic [26:0] frameID,
  input  logic        sig_ram_last,
  input  logic        has_cluster,
  input  logic        no_cluster,
  input  logic [8:0]  sig_ch_left,
  input  logic [8:0]  sig_ch_right,
  output logic [8:0]  sig_rdaddress,
  input  logic [31:0] sig_out,
  output logic [31:0] data_out_data,
  output logic        data_out_valid,
  input  logic        data_out_ready,
  output logic        data_out_startofpacket,
  output logic        data_out_endofpacket,
  output logic [1:0]  data_out_empty,
  output logic        busy,
  output logic [7:0]  drop_count,
  output logic [2:0]  dbg_state
);

  localparam logic [8:0] LAST_CH  = 9'(NUM_CH - 1);
  localparam logic [9:0] MAXW     = 10'(MAX_WIDTH);
  localparam logic [8:0] MAXW9    = 9'(MAX_WIDTH);
  localparam logic [1:0] LAT_LAST = 2'(RD_LATENCY - 1);

  sig_state_e  state_q, state_d;

  logic [26:0] frame_q;
  logic        has_q;
  logic        trunc_q;
  logic [8:0]  left_q;
  logic [8:0]  right_q;
  logic [8:0]  count_q;
  logic [8:0]  ch_q;
  logic [8:0]  addr_q;
  logic [1:0]  wait_q;
  logic [15:0] hold_q;
  logic [7:0]  drop_q;

  logic [31:0] sum;
  logic [31:0] wsum;
  logic        capture;
  logic        smp_accept;

  // no_cluster is implied by has_cluster=0; upper RAM bits carry no sample.
  logic unused_bits;
  assign unused_bits = ^{no_cluster, sig_out[31:16]};

  // ---------------------------------------------------------------------
  // Cluster range qualification, evaluated on the capture cycle.
  // Order matters: clamp right to the last channel first, then decide
  // validity, then truncate the width.
  // ---------------------------------------------------------------------
  logic [8:0] right_clamp;
  logic       cl_valid;
  logic [9:0] span;
  logic       cl_trunc;
  logic [8:0] right_eff;
  logic [8:0] count_eff;

  always_comb begin
    right_clamp = (sig_ch_right > LAST_CH) ? LAST_CH : sig_ch_right;
    cl_valid    = has_cluster && (sig_ch_left <= right_clamp) &&
                  (sig_ch_left <= LAST_CH);
    span        = {1'b0, right_clamp} - {1'b0, sig_ch_left} + 10'd1;
    cl_trunc    = 1'b0;
    right_eff   = right_clamp;
    count_eff   = '0;
    if (cl_valid) begin
      if (span > MAXW) begin
        cl_trunc  = 1'b1;
        right_eff = sig_ch_left + MAXW9 - 9'd1;
        count_eff = MAXW9;
      end else begin
        count_eff = span[8:0];
      end
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d                = state_q;
    data_out_data          = '0;
    data_out_valid         = 1'b0;
    data_out_startofpacket = 1'b0;
    data_out_endofpacket   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sig_ram_last) state_d = S_HDR0;
      end
      S_HDR0: begin
        data_out_valid         = 1'b1;
        data_out_startofpacket = 1'b1;
        data_out_data          = pack_hdr0(MAGIC, frame_q);
        if (data_out_ready) state_d = S_HDR1;
      end
      S_HDR1: begin
        data_out_valid = 1'b1;
        data_out_data  = pack_hdr1(has_q, trunc_q, left_q, right_q, count_q);
        if (data_out_ready) state_d = (count_q != 9'd0) ? S_RD_ISSUE : S_SUM;
      end
      S_RD_ISSUE: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (wait_q == LAT_LAST) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        data_out_valid = 1'b1;
        data_out_data  = pack_sample(ch_q, hold_q);
        if (data_out_ready) state_d = (ch_q == right_q) ? S_SUM : S_RD_ISSUE;
      end
      S_SUM: begin
        data_out_valid = 1'b1;
        data_out_data  = sum;
        if (data_out_ready) state_d = S_WSUM;
      end
      S_WSUM: begin
        data_out_valid       = 1'b1;
        data_out_endofpacket = 1'b1;
        data_out_data        = wsum;
        if (data_out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign capture    = (state_q == S_IDLE) && sig_ram_last;
  assign smp_accept = (state_q == S_SAMPLE) && data_out_ready;

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_clk or negedge rst_reset_n) begin
    if (!rst_reset_n) begin
      frame_q <= '0;
      has_q   <= 1'b0;
      trunc_q <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      count_q <= '0;
      ch_q    <= '0;
      addr_q  <= '0;
      wait_q  <= '0;
      hold_q  <= '0;
      drop_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sig_ram_last) begin
            frame_q <= frameID;
            has_q   <= has_cluster;
            trunc_q <= cl_trunc;
            left_q  <= sig_ch_left;
            right_q <= right_eff;
            count_q <= count_eff;
            ch_q    <= sig_ch_left;
          end
        end
        // The address register is loaded on the way into RD_ISSUE so the
        // RAM sees the channel during RD_ISSUE and keeps it afterwards.
        S_HDR1: begin
          if (data_out_ready && (count_q != 9'd0)) addr_q <= ch_q;
        end
        S_RD_ISSUE: begin
          wait_q <= '0;
        end
        S_RD_WAIT: begin
          if (wait_q == LAT_LAST) hold_q <= sig_out[15:0];
          else                    wait_q <= wait_q + 2'd1;
        end
        S_SAMPLE: begin
          if (data_out_ready && (ch_q != right_q)) begin
            ch_q   <= ch_q + 9'd1;
            addr_q <= ch_q + 9'd1;
          end
        end
        default: ;
      endcase

      if (sig_ram_last && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  cluster_accumulator u_accum (
    .clk_clk     (clk_clk),
    .rst_reset_n (rst_reset_n),
    .clear       (capture),
    .enable      (smp_accept),
    .ch          (ch_q),
    .sample      (hold_q),
    .sum         (sum),
    .wsum        (wsum)
  );

  assign sig_rdaddress  = addr_q;
  assign data_out_empty = 2'b00;
  assign busy           = (state_q != S_IDLE);
  assign drop_count     = drop_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_sig_cluster_reader.sv
module tb_sig_cluster_reader;
  import sig_reader_pkg::*;

  localparam int RD_LAT = 2;

  // ---------------- clock / reset ----------------
  logic        clk_clk = 1'b0;
  logic        rst_reset_n = 1'b0;
  always #5 clk_clk = ~clk_clk;

  logic [26:0] frameID = '0;
  logic        sig_ram_last = 1'b0;
  logic        has_cluster = 1'b0;
  logic        no_cluster = 1'b0;
  logic [8:0]  sig_ch_left = '0;
  logic [8:0]  sig_ch_right = '0;
  logic [8:0]  sig_rdaddress;
  logic [31:0] sig_out;
  logic [31:0] data_out_data;
  logic        data_out_valid;
  logic        data_out_ready = 1'b1;
  logic        data_out_startofpacket;
  logic        data_out_endofpacket;
  logic [1:0]  data_out_empty;
  logic        busy;
  logic [7:0]  drop_count;
  logic [2:0]  dbg_state;

  sig_cluster_reader #(
    .RD_LATENCY (RD_LAT),
    .MAX_WIDTH  (64),
    .NUM_CH     (320),
    .MAGIC      (5'h15)
  ) dut (
    .clk_clk                (clk_clk),
    .rst_reset_n            (rst_reset_n),
    .frameID                (frameID),
    .sig_ram_last           (sig_ram_last),
    .has_cluster            (has_cluster),
    .no_cluster             (no_cluster),
    .sig_ch_left            (sig_ch_left),
    .sig_ch_right           (sig_ch_right),
    .sig_rdaddress          (sig_rdaddress),
    .sig_out                (sig_out),
    .data_out_data          (data_out_data),
    .data_out_valid         (data_out_valid),
    .data_out_ready         (data_out_ready),
    .data_out_startofpacket (data_out_startofpacket),
    .data_out_endofpacket   (data_out_endofpacket),
    .data_out_empty         (data_out_empty),
    .busy                   (busy),
    .drop_count             (drop_count),
    .dbg_state              (dbg_state)
  );

  // ---------------- RAM model (RD_LAT clocks read latency) ----------------
  logic [31:0] mem [0:511];
  logic [31:0] rd_pipe [RD_LAT];
  always @(posedge clk_clk) begin
    rd_pipe[0] <= mem[sig_rdaddress];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sig_out = rd_pipe[RD_LAT-1];

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- ready driver ----------------
  int ready_mode = 0;
  int rdy_phase  = 0;
  initial begin
    forever begin
      @(posedge clk_clk);
      #1;
      if (ready_mode == 0) begin
        data_out_ready = 1'b1;
      end else begin
        // 1-0-0-1 repeating
        data_out_ready = ((rdy_phase % 4) == 0) || ((rdy_phase % 4) == 3);
        rdy_phase++;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [33:0] exp_q[$];   // {sop, eop, data}
  int          pkt_done = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk_clk);
      if (!rst_reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold", 64'({data_out_valid, data_out_data}), 64'({1'b1, prev_data}));
        prev_stall = data_out_valid && !data_out_ready;
        prev_data  = data_out_data;
        if (data_out_valid && data_out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_word", 64'(data_out_data), 64'hFFFF_FFFF_0000_0000);
          end else begin
            e = exp_q.pop_front();
            check("word", 64'({data_out_startofpacket, data_out_endofpacket, data_out_data}), 64'(e));
            if (data_out_endofpacket) pkt_done++;
          end
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [26:0] frame;
    logic        has;
    logic [8:0]  left;
    logic [8:0]  right;
    int          rmode;
    bit          extra_pulse;
    logic [31:0] exp_hdr1;
    logic [31:0] exp_sum;
    logic [31:0] exp_wsum;
  } vec_t;

  vec_t vecs[7];
  int   exp_drop = 0;

  task automatic build_exp(input vec_t v);
    int n;
    logic [8:0] c;
    exp_q.push_back({1'b1, 1'b0, 5'h15, v.frame});
    exp_q.push_back({2'b00, v.exp_hdr1});
    n = int'(v.exp_hdr1[8:0]);
    for (int i = 0; i < n; i++) begin
      c = v.left + 9'(i);
      exp_q.push_back({2'b00, 7'b0, c, mem[c][15:0]});
    end
    exp_q.push_back({2'b00, v.exp_sum});
    exp_q.push_back({2'b01, v.exp_wsum});
  endtask

  task automatic launch(input vec_t v);
    ready_mode = v.rmode;
    rdy_phase  = 0;
    @(posedge clk_clk);
    #1;
    frameID      = v.frame;
    has_cluster  = v.has;
    no_cluster   = ~v.has;
    sig_ch_left  = v.left;
    sig_ch_right = v.right;
    sig_ram_last = 1'b1;
    @(posedge clk_clk);
    #1;
    sig_ram_last = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int start;
    int cyc;
    build_exp(v);
    start = pkt_done;
    launch(v);
    if (v.extra_pulse) begin
      repeat (3) @(posedge clk_clk);
      #1;
      check("busy_mid", 64'(busy), 64'd1);
      sig_ram_last = 1'b1;
      if (exp_drop < 255) exp_drop++;
      @(posedge clk_clk);
      #1;
      sig_ram_last = 1'b0;
    end
    cyc = 0;
    while (pkt_done == start && cyc < 3000) begin
      @(negedge clk_clk);
      cyc++;
    end
    check("pkt_complete", 64'(pkt_done - start), 64'd1);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk_clk);
    check("idle_after", 64'({busy, dbg_state}), 64'd0);
    check("drop_count", 64'(drop_count), 64'(exp_drop));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    for (int i = 0; i < 512; i++) mem[i] = {16'h5A5A, 16'(i)};
    mem[10] = {16'hDEAD, 16'd100};
    mem[11] = {16'hDEAD, 16'd200};
    mem[12] = {16'hDEAD, 16'd300};
    mem[13] = {16'hDEAD, 16'd100};
    mem[5]  = {16'hBEEF, 16'hFFCE};  // -50
    mem[6]  = {16'hBEEF, 16'd80};

    //          frame has left right mode xp  hdr1          sum  wsum
    vecs[0] = '{27'd5,  1'b1, 9'd10, 9'd13,  0, 1'b0, 32'h80281A04, 32'd700, 32'd8100};
    vecs[1] = '{27'd6,  1'b1, 9'd10, 9'd13,  1, 1'b0, 32'h80281A04, 32'd700, 32'd8100};
    vecs[2] = '{27'd7,  1'b0, 9'd0,  9'd0,   0, 1'b0, 32'h00000000, 32'd0,   32'd0};
`ifdef SIG_READER_NEG_CLIP_EN
    vecs[3] = '{27'd8,  1'b1, 9'd0,  9'd100, 0, 1'b0, 32'hC0007E40, 32'd2739, 32'd93329};
    vecs[4] = '{27'd9,  1'b1, 9'd5,  9'd6,   1, 1'b1, 32'h80140C02, 32'd80,   32'd480};
`else
    vecs[3] = '{27'd8,  1'b1, 9'd0,  9'd100, 0, 1'b0, 32'hC0007E40, 32'd2689, 32'd93079};
    vecs[4] = '{27'd9,  1'b1, 9'd5,  9'd6,   1, 1'b1, 32'h80140C02, 32'd30,   32'd230};
`endif
    vecs[5] = '{27'd10, 1'b1, 9'd318, 9'd400, 0, 1'b0, 32'h84FA7E02, 32'd637, 32'd202885};
    vecs[6] = '{27'd11, 1'b1, 9'd20, 9'd10,  1, 1'b0, 32'h80501400, 32'd0,   32'd0};

    rst_reset_n = 1'b0;
    repeat (3) @(posedge clk_clk);
    @(negedge clk_clk);
    check("reset_stream", 64'({data_out_valid, data_out_startofpacket, data_out_endofpacket, data_out_data}), 64'd0);
    check("reset_misc", 64'({busy, drop_count, sig_rdaddress, data_out_empty, dbg_state}), 64'd0);
    rst_reset_n = 1'b1;
    repeat (2) @(posedge clk_clk);

    for (int v = 0; v < 7; v++) run_vec(vecs[v]);

    // Reset during the sample phase aborts the packet at once.
    build_exp(vecs[0]);
    launch(vecs[0]);
    cyc = 0;
    while (dbg_state != S_SAMPLE && cyc < 100) begin
      @(negedge clk_clk);
      cyc++;
    end
    check("reach_sample", 64'(dbg_state), 64'(S_SAMPLE));
    #2;
    rst_reset_n = 1'b0;
    #1;
    check("async_reset_valid", 64'({data_out_valid, data_out_endofpacket}), 64'd0);
    check("async_reset_state", 64'({busy, dbg_state, drop_count}), 64'd0);
    exp_q.delete();
    exp_drop = 0;
    repeat (2) @(negedge clk_clk);
    rst_reset_n = 1'b1;
    repeat (2) @(posedge clk_clk);
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
